// File: rtl/pygmy_cfg.sv
// Pygmy SoC configuration constants shared by the cache/NoC blocks.
package pygmy_cfg;
  localparam int N_BANK      = 4;
  localparam int PADDR_W     = 40;
  localparam int BANK_ID_LSB = 6;
  localparam int BANK_ID_MSB = 7;
endpackage

// File: rtl/pygmy_typedef.sv
// Pygmy SoC cpu_cache_if request/response payload types.
package pygmy_typedef;
  import pygmy_cfg::*;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic               is_write;
    logic [3:0]         tid;
    logic [31:0]        wdata;
  } cpu_cache_if_req_t;

  typedef struct packed {
    logic [3:0]  tid;
    logic        is_write;
    logic [31:0] rdata;
  } cpu_cache_if_resp_t;
endpackage

// File: rtl/usb_noc_bank_resp_ord_pkg.sv
// Local helpers for the USB/SDIO NoC bank response ordering block.
package usb_noc_bank_resp_ord_pkg;
  localparam int IDX_W = $clog2(pygmy_cfg::N_BANK);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == pygmy_cfg::N_BANK - 1) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/usb_noc_resp_arb.sv
// Response arbiter: eligibility from ROB age hints, oldest-first then
// round-robin selection, and a lock that keeps a presented response stable.
module usb_noc_resp_arb
  import pygmy_cfg::*;
  import usb_noc_bank_resp_ord_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_BANK-1:0] buf_vld,
  input  logic [N_BANK-1:0] entry_vld_pbank,
  input  logic [N_BANK-1:0] is_oldest_pbank,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [IDX_W-1:0]  sel
);
  logic [N_BANK-1:0] elig;
  logic              old_hit;
  logic [IDX_W-1:0]  old_sel;
  logic [IDX_W-1:0]  rr_sel;
  logic [IDX_W-1:0]  k;
  logic              via_rr;
  logic              resp_hs;
  logic              lock_vld_q, lock_vld_d;
  logic              lock_rr_q, lock_rr_d;
  logic [IDX_W-1:0]  lock_sel_q, lock_sel_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  assign elig = buf_vld & (is_oldest_pbank | ~entry_vld_pbank);

  // Scan downwards so the lowest index / nearest-to-rr_ptr candidate wins.
  always_comb begin
    old_hit = 1'b0;
    old_sel = '0;
    rr_sel  = '0;
    k       = '0;
    for (int i = N_BANK - 1; i >= 0; i--) begin
      if (elig[i] & entry_vld_pbank[i] & is_oldest_pbank[i]) begin
        old_hit = 1'b1;
        old_sel = IDX_W'(i);
      end
    end
    for (int i = N_BANK - 1; i >= 0; i--) begin
      k = rr_ptr_q + IDX_W'(i);
      if (elig[k]) rr_sel = k;
    end
  end

  always_comb begin
    if (lock_vld_q) begin
      resp_valid = 1'b1;
      sel        = lock_sel_q;
      via_rr     = lock_rr_q;
    end else if (old_hit) begin
      resp_valid = 1'b1;
      sel        = old_sel;
      via_rr     = 1'b0;
    end else begin
      resp_valid = |elig;
      sel        = rr_sel;
      via_rr     = 1'b1;
    end
    resp_hs    = resp_valid & resp_ready;
    lock_vld_d = resp_valid & ~resp_ready;
    lock_sel_d = sel;
    lock_rr_d  = via_rr;
    rr_ptr_d   = (resp_hs & via_rr) ? next_idx(sel) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_vld_q <= 1'b0;
      lock_rr_q  <= 1'b0;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_rr_q  <= lock_rr_d;
      lock_sel_q <= lock_sel_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end
endmodule

// File: rtl/usb_noc_bank_resp_ord.sv
// NoC side of the USB/SDIO request ROB: steers requests to L2 banks and
// returns buffered bank responses to the ROB in issue order.
module usb_noc_bank_resp_ord
  import pygmy_cfg::*;
  import pygmy_typedef::*;
  import usb_noc_bank_resp_ord_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                rob_noc_req_if_req_valid,
  output logic                                rob_noc_req_if_req_ready,
  input  cpu_cache_if_req_t                   rob_noc_req_if_req,
  output logic                                noc_rob_resp_if_resp_valid,
  input  logic                                noc_rob_resp_if_resp_ready,
  output cpu_cache_if_resp_t                  noc_rob_resp_if_resp,
  input  logic [N_BANK-1:0]                   entry_vld_pbank,
  input  logic [N_BANK-1:0]                   is_oldest_pbank,
  output logic [N_BANK-1:0]                   noc_bank_req_valid,
  input  logic [N_BANK-1:0]                   noc_bank_req_ready,
  output cpu_cache_if_req_t [N_BANK-1:0]      noc_bank_req,
  input  logic [N_BANK-1:0]                   bank_noc_resp_valid,
  output logic [N_BANK-1:0]                   bank_noc_resp_ready,
  input  cpu_cache_if_resp_t [N_BANK-1:0]     bank_noc_resp
);
  logic                            req_vld_q, req_vld_d;
  cpu_cache_if_req_t               req_q, req_d;
  logic [IDX_W-1:0]                req_bank_q, req_bank_d;
  logic [N_BANK-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BANK-1:0]               buf_vld_q, buf_vld_d;
  cpu_cache_if_resp_t [N_BANK-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]                in_bank;
  logic [IDX_W-1:0]                sel;
  logic [CNT_W:0]                  in_load;
  logic                            bank_hs, req_acc, resp_hs;
  logic [N_BANK-1:0]               deq, bank_acc, bank_issue;

  assign in_bank = rob_noc_req_if_req.paddr[BANK_ID_MSB:BANK_ID_LSB];
  assign bank_hs = req_vld_q & noc_bank_req_ready[req_bank_q];
  // A request parked in req_q for the same bank counts against the limit,
  // otherwise back-to-back accepts could push a counter past MAX_OUTST.
  assign in_load = {1'b0, cnt_q[in_bank]}
                 + {{CNT_W{1'b0}}, (req_vld_q && (req_bank_q == in_bank))};
  assign rob_noc_req_if_req_ready = (~req_vld_q | bank_hs)
                                  & (in_load < (CNT_W + 1)'(MAX_OUTST));
  assign req_acc = rob_noc_req_if_req_valid & rob_noc_req_if_req_ready;

  usb_noc_resp_arb u_arb (
    .clk             (clk),
    .rstn            (rstn),
    .buf_vld         (buf_vld_q),
    .entry_vld_pbank (entry_vld_pbank),
    .is_oldest_pbank (is_oldest_pbank),
    .resp_ready      (noc_rob_resp_if_resp_ready),
    .resp_valid      (noc_rob_resp_if_resp_valid),
    .sel             (sel)
  );

  assign resp_hs              = noc_rob_resp_if_resp_valid & noc_rob_resp_if_resp_ready;
  assign noc_rob_resp_if_resp = buf_q[sel];
  assign bank_noc_resp_ready  = ~buf_vld_q | deq;
  assign bank_acc             = bank_noc_resp_valid & bank_noc_resp_ready;

  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      noc_bank_req_valid[b] = req_vld_q & (req_bank_q == IDX_W'(b));
      noc_bank_req[b]       = req_q;
      deq[b]                = resp_hs & (sel == IDX_W'(b));
      bank_issue[b]         = bank_hs & (req_bank_q == IDX_W'(b));
    end
  end

  always_comb begin
    req_vld_d  = req_vld_q;
    req_d      = req_q;
    req_bank_d = req_bank_q;
    if (req_acc) begin
      req_vld_d  = 1'b1;
      req_d      = rob_noc_req_if_req;
      req_bank_d = in_bank;
    end else if (bank_hs) begin
      req_vld_d = 1'b0;
    end
    buf_vld_d = (buf_vld_q & ~deq) | bank_acc;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    for (int b = 0; b < N_BANK; b++) begin
      if (bank_acc[b]) buf_d[b] = bank_noc_resp[b];
      cnt_d[b] = cnt_q[b] + CNT_W'(bank_issue[b]) - CNT_W'(bank_acc[b]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_vld_q  <= 1'b0;
      req_q      <= '0;
      req_bank_q <= '0;
      cnt_q      <= '0;
      buf_vld_q  <= '0;
      buf_q      <= '0;
    end else begin
      req_vld_q  <= req_vld_d;
      req_q      <= req_d;
      req_bank_q <= req_bank_d;
      cnt_q      <= cnt_d;
      buf_vld_q  <= buf_vld_d;
      buf_q      <= buf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int b = 0; b < N_BANK; b++) begin
        assert (!(bank_issue[b] && !bank_acc[b] && (cnt_q[b] == CNT_W'(MAX_OUTST))));
      end
    end
  end
endmodule

// File: tb/tb_usb_noc_bank_resp_ord.sv
// Bench for usb_noc_bank_resp_ord: directed ordering/lock/backpressure cases
// plus random traffic against a transaction-level reference model.
module tb_usb_noc_bank_resp_ord;
  import pygmy_cfg::*;
  import pygmy_typedef::*;

  localparam int MAX_OUTST = 4;
  localparam int BW = BANK_ID_MSB - BANK_ID_LSB + 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                            rob_req_valid;
  logic                            rob_req_ready;
  cpu_cache_if_req_t               rob_req;
  logic                            resp_valid;
  logic                            resp_ready;
  cpu_cache_if_resp_t              resp;
  logic [N_BANK-1:0]               entry_vld;
  logic [N_BANK-1:0]               is_oldest;
  logic [N_BANK-1:0]               noc_bank_req_valid;
  logic [N_BANK-1:0]               noc_bank_req_ready;
  cpu_cache_if_req_t [N_BANK-1:0]  noc_bank_req;
  logic [N_BANK-1:0]               bank_noc_resp_valid;
  logic [N_BANK-1:0]               bank_noc_resp_ready;
  cpu_cache_if_resp_t [N_BANK-1:0] bank_noc_resp;

  usb_noc_bank_resp_ord #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .rob_noc_req_if_req_valid   (rob_req_valid),
    .rob_noc_req_if_req_ready   (rob_req_ready),
    .rob_noc_req_if_req         (rob_req),
    .noc_rob_resp_if_resp_valid (resp_valid),
    .noc_rob_resp_if_resp_ready (resp_ready),
    .noc_rob_resp_if_resp       (resp),
    .entry_vld_pbank            (entry_vld),
    .is_oldest_pbank            (is_oldest),
    .noc_bank_req_valid         (noc_bank_req_valid),
    .noc_bank_req_ready         (noc_bank_req_ready),
    .noc_bank_req               (noc_bank_req),
    .bank_noc_resp_valid        (bank_noc_resp_valid),
    .bank_noc_resp_ready        (bank_noc_resp_ready),
    .bank_noc_resp              (bank_noc_resp)
  );

  // Reference model state: transaction-level view of what the block holds.
  logic               m_req_vld;
  cpu_cache_if_req_t  m_req;
  int                 m_req_bank;
  int                 m_cnt [N_BANK];
  logic               m_buf_vld [N_BANK];
  cpu_cache_if_resp_t m_buf [N_BANK];
  int                 m_lock;
  bit                 m_lock_rr;
  int                 m_rr;
  int                 tb_owed [N_BANK];

  int n_vec = 0;
  int n_err = 0;

  logic                           obs_rdy, obs_vld;
  logic [3:0]                     obs_tid;
  cpu_cache_if_req_t [N_BANK-1:0] obs_breq;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req_vld  = 1'b0;
    m_req      = '0;
    m_req_bank = 0;
    m_lock     = -1;
    m_lock_rr  = 1'b0;
    m_rr       = 0;
    for (int b = 0; b < N_BANK; b++) begin
      m_cnt[b]     = 0;
      m_buf_vld[b] = 1'b0;
      m_buf[b]     = '0;
      tb_owed[b]   = 0;
    end
  endtask

  // Called at a negedge with inputs driven; checks, advances the model, and
  // returns at the next negedge.
  task automatic cycle();
    int                in_bank, sel, load;
    bit                bank_hs, via_rr, vld, rhs, e_rdy, acc;
    logic [N_BANK-1:0] elig, e_brdy, taken;
    in_bank = int'(rob_req.paddr[BANK_ID_MSB:BANK_ID_LSB]);
    bank_hs = m_req_vld && noc_bank_req_ready[m_req_bank];
    load    = m_cnt[in_bank] + ((m_req_vld && m_req_bank == in_bank) ? 1 : 0);
    e_rdy   = (!m_req_vld || bank_hs) && (load < MAX_OUTST);
    for (int b = 0; b < N_BANK; b++)
      elig[b] = m_buf_vld[b] && (is_oldest[b] || !entry_vld[b]);
    sel    = -1;
    via_rr = 1'b0;
    if (m_lock >= 0) begin
      sel    = m_lock;
      via_rr = m_lock_rr;
    end else begin
      for (int b = 0; b < N_BANK; b++)
        if (sel < 0 && elig[b] && entry_vld[b] && is_oldest[b]) sel = b;
      if (sel < 0) begin
        for (int j = 0; j < N_BANK; j++)
          if (sel < 0 && elig[(m_rr + j) % N_BANK]) sel = (m_rr + j) % N_BANK;
        via_rr = 1'b1;
      end
    end
    vld = (sel >= 0);
    rhs = vld && resp_ready;
    for (int b = 0; b < N_BANK; b++)
      e_brdy[b] = !m_buf_vld[b] || (rhs && sel == b);
    #1;
    obs_rdy  = rob_req_ready;
    obs_vld  = resp_valid;
    obs_tid  = resp.tid;
    obs_breq = noc_bank_req;
    chk("rob_req_ready", 128'(rob_req_ready), 128'(e_rdy));
    chk("bank_req_valid", 128'(noc_bank_req_valid),
        128'(m_req_vld ? (N_BANK'(1) << m_req_bank) : N_BANK'(0)));
    if (m_req_vld) chk("bank_req_payload", 128'(noc_bank_req[m_req_bank]), 128'(m_req));
    chk("bank_resp_ready", 128'(bank_noc_resp_ready), 128'(e_brdy));
    chk("resp_valid", 128'(resp_valid), 128'(vld));
    if (vld) chk("resp_payload", 128'(resp), 128'(m_buf[sel]));
    // advance model
    acc = rob_req_valid && e_rdy;
    if (bank_hs) begin
      m_cnt[m_req_bank]++;
      tb_owed[m_req_bank]++;
    end
    if (acc) begin
      m_req_vld  = 1'b1;
      m_req      = rob_req;
      m_req_bank = in_bank;
    end else if (bank_hs) begin
      m_req_vld = 1'b0;
    end
    if (rhs) begin
      m_buf_vld[sel] = 1'b0;
      if (via_rr) m_rr = (sel + 1) % N_BANK;
    end
    m_lock    = (vld && !resp_ready) ? sel : -1;
    m_lock_rr = via_rr;
    for (int b = 0; b < N_BANK; b++) begin
      taken[b] = bank_noc_resp_valid[b] && e_brdy[b];
      if (taken[b]) begin
        m_cnt[b]--;
        m_buf_vld[b] = 1'b1;
        m_buf[b]     = bank_noc_resp[b];
      end
    end
    @(negedge clk);
    for (int b = 0; b < N_BANK; b++)
      if (taken[b]) bank_noc_resp_valid[b] = 1'b0;
    if (acc) rob_req_valid = 1'b0;
  endtask

  task automatic set_req(input int bank, input logic [3:0] tid, input logic wr);
    rob_req_valid  = 1'b1;
    rob_req.paddr  = PADDR_W'({$urandom, $urandom});
    rob_req.paddr[BANK_ID_MSB:BANK_ID_LSB] = BW'(bank);
    rob_req.tid      = tid;
    rob_req.is_write = wr;
    rob_req.wdata    = $urandom;
  endtask

  task automatic send(input int bank, input logic [3:0] tid, input logic wr);
    set_req(bank, tid, wr);
    for (int i = 0; i < 20 && rob_req_valid; i++) cycle();
    chk("send_accept", 128'(rob_req_valid), 128'(0));
  endtask

  task automatic present(input int b, input logic [3:0] tid);
    bank_noc_resp_valid[b] = 1'b1;
    bank_noc_resp[b]       = '{tid: tid, is_write: 1'b0, rdata: $urandom};
    if (tb_owed[b] > 0) tb_owed[b]--;
  endtask

  task automatic drive_random();
    int k;
    set_req(int'($urandom_range(0, N_BANK - 1)), 4'($urandom), 1'($urandom));
    if ($urandom_range(0, 3) == 0) rob_req.paddr[BANK_ID_MSB:BANK_ID_LSB] = BW'(1);
    rob_req_valid      = 1'($urandom_range(0, 1));
    noc_bank_req_ready = N_BANK'($urandom);
    entry_vld          = N_BANK'($urandom);
    k                  = int'($urandom_range(0, N_BANK - 1));
    is_oldest          = (entry_vld[k] && $urandom_range(0, 1) == 1) ? N_BANK'(1 << k) : '0;
    resp_ready         = ($urandom_range(0, 3) != 0);
    for (int b = 0; b < N_BANK; b++)
      if (!bank_noc_resp_valid[b] && tb_owed[b] > 0 && $urandom_range(0, 2) == 0)
        present(b, 4'($urandom));
  endtask

  cpu_cache_if_req_t saved_req;

  initial begin
    rstn                = 1'b0;
    rob_req_valid       = 1'b0;
    rob_req             = '0;
    resp_ready          = 1'b0;
    entry_vld           = '0;
    is_oldest           = '0;
    noc_bank_req_ready  = '0;
    bank_noc_resp_valid = '0;
    bank_noc_resp       = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rob_ready", 128'(rob_req_ready), 128'(1));
    chk("reset_resp_valid", 128'(resp_valid), 128'(0));
    chk("reset_bank_req_valid", 128'(noc_bank_req_valid), 128'(0));
    chk("reset_bank_resp_ready", 128'(bank_noc_resp_ready), 128'({N_BANK{1'b1}}));
    @(negedge clk);
    rstn = 1'b1;

    // 1: tracked read B in bank 0 waits behind older read A in bank 2
    noc_bank_req_ready = '1;
    resp_ready         = 1'b1;
    send(2, 4'hA, 1'b0);
    send(0, 4'hB, 1'b0);
    cycle();
    entry_vld = 4'b0101;
    is_oldest = 4'b0100;
    present(0, 4'hB);
    cycle();
    cycle();
    chk("t1_b_held", 128'(obs_vld), 128'(0));
    present(2, 4'hA);
    cycle();
    cycle();
    chk("t1_a_valid", 128'(obs_vld), 128'(1));
    chk("t1_a_first", 128'(obs_tid), 128'(4'hA));
    entry_vld = 4'b0001;
    is_oldest = 4'b0001;
    cycle();
    chk("t1_b_second", 128'(obs_tid), 128'(4'hB));

    // 2: untracked write acks in banks 1 and 3 drain round-robin
    entry_vld  = '0;
    is_oldest  = '0;
    send(1, 4'h1, 1'b1);
    send(3, 4'h3, 1'b1);
    cycle();
    resp_ready = 1'b0;
    present(1, 4'h1);
    present(3, 4'h3);
    cycle();
    resp_ready = 1'b1;
    cycle();
    chk("t2_bank1_first", 128'(obs_tid), 128'(4'h1));
    cycle();
    chk("t2_bank3_second", 128'(obs_tid), 128'(4'h3));

    // 3: a presented response stays locked when eligibility drops
    resp_ready = 1'b0;
    send(3, 4'h3, 1'b1);
    cycle();
    present(3, 4'h7);
    cycle();
    cycle();
    chk("t3_presented", 128'(obs_vld), 128'(1));
    entry_vld = 4'b1000;
    cycle();
    chk("t3_lock_valid", 128'(obs_vld), 128'(1));
    chk("t3_lock_payload", 128'(obs_tid), 128'(4'h7));
    resp_ready = 1'b1;
    cycle();
    cycle();
    chk("t3_drained", 128'(obs_vld), 128'(0));

    // 4: outstanding limit on bank 1
    entry_vld = '0;
    for (int i = 0; i < MAX_OUTST; i++) send(1, 4'(i), 1'b0);
    cycle();
    set_req(1, 4'hE, 1'b0);
    cycle();
    chk("t4_full", 128'(obs_rdy), 128'(0));
    present(1, 4'h0);
    cycle();
    chk("t4_still_full", 128'(obs_rdy), 128'(0));
    cycle();
    chk("t4_reopen", 128'(obs_rdy), 128'(1));

    // 5: bank backpressure keeps the request register stable
    cycle();
    noc_bank_req_ready = '0;
    send(0, 4'h5, 1'b0);
    saved_req = rob_req;
    set_req(2, 4'h6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_ready_low", 128'(obs_rdy), 128'(0));
      chk("t5_payload", 128'(obs_breq[0]), 128'(saved_req));
    end
    noc_bank_req_ready = '1;
    for (int i = 0; i < 3; i++) cycle();
    rob_req_valid = 1'b0;

    // random traffic, then async reset with buffers loaded, then more traffic
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      cycle();
    end
    for (int i = 0; i < 12; i++) begin
      drive_random();
      resp_ready = 1'b0;
      cycle();
    end
    drive_random();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_bank_req_valid", 128'(noc_bank_req_valid), 128'(0));
    chk("rst_bank_resp_ready", 128'(bank_noc_resp_ready), 128'({N_BANK{1'b1}}));
    rob_req_valid       = 1'b0;
    bank_noc_resp_valid = '0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_release_ready", 128'(rob_req_ready), 128'(1));
    @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/usb_noc_bank_resp_ord.md
Name: usb_noc_bank_resp_ord

Overview:
- NoC-side counterpart of the USB/SDIO request ROB.
- Accepts cpu_cache_if requests from the ROB, steers each to an L2 bank by the paddr bank bits, and buffers bank responses.
- Returns responses to the ROB oldest-first, using the ROB's entry_vld_pbank/is_oldest_pbank age hints, so tracked reads complete in issue order.

Parameters:
N_BANK, pygmy_cfg::N_BANK (4), number of L2 banks
MAX_OUTST, 4, max outstanding requests per bank
CNT_W, $clog2(MAX_OUTST+1), outstanding counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
rob_noc_req_if_req_valid  in  1  request valid from ROB
rob_noc_req_if_req_ready  out  1  request ready to ROB
rob_noc_req_if_req  in  cpu_cache_if_req_t  request payload
noc_rob_resp_if_resp_valid  out  1  response valid to ROB
noc_rob_resp_if_resp_ready  in  1  response ready from ROB
noc_rob_resp_if_resp  out  cpu_cache_if_resp_t  response payload
entry_vld_pbank  in  N_BANK  ROB holds a tracked read per bank
is_oldest_pbank  in  N_BANK  that bank's tracked read is oldest
noc_bank_req_valid  out  N_BANK  request valid per bank
noc_bank_req_ready  in  N_BANK  bank ready
noc_bank_req  out  N_BANK x cpu_cache_if_req_t  request per bank, broadcast from the request register
bank_noc_resp_valid  in  N_BANK  bank response valid
bank_noc_resp_ready  out  N_BANK  bank response ready
bank_noc_resp  in  N_BANK x cpu_cache_if_resp_t  bank response payload

Behaviour:
- Interface fixed: one clock clk; reset rstn asynchronous, active-low. All flops clear on rstn low regardless of clk.
- Reset state: request register empty; response buffers empty; outstanding counters 0; rr_ptr 0; lock clear.
- Reset output values: all valids 0; rob_noc_req_if_req_ready 1; bank_noc_resp_ready all 1.
- Request path:
  - One-entry request register req_q, holding payload and bank = req_paddr[BANK_ID_MSB:BANK_ID_LSB].
  - rob_noc_req_if_req_ready = (~req_q_vld | bank handshake this cycle) & (cnt[bank of incoming] < MAX_OUTST).
  - The incoming bank is decoded combinationally from rob_noc_req_if_req.
  - noc_bank_req_valid[b] = req_q_vld & (req_q_bank == b). Latency: 1 cycle ROB accept to bank valid.
  - Back-to-back accept is allowed when req_q drains in the same cycle.
  - Payload holds stable while valid & ~ready.
- Outstanding counters:
  - cnt[b] +1 on bank request handshake; -1 on bank response handshake into the buffer; both in the same cycle leaves it unchanged.
  - Counter saturation is an assertion error.
- Response buffers:
  - One entry per bank.
  - bank_noc_resp_ready[b] = ~buf_vld[b] | (buffer b dequeued this cycle).
- Eligibility: elig[b] = buf_vld[b] & (is_oldest_pbank[b] | ~entry_vld_pbank[b]).
- Output selection:
  - The oldest eligible bank has priority.
  - Otherwise, round-robin over elig starting at rr_ptr.
  - noc_rob_resp_if_resp_valid = |elig | lock. The response is the selected buffer, combinational from the buffer flops.
- Lock:
  - When valid & ~ready, sel is latched into lock_q. The next cycle presents the same bank regardless of hint changes.
  - A new ROB alloc may drop eligibility; a locked response must not be withdrawn.
  - lock clears on handshake.
- On handshake: the buffer empties; rr_ptr = sel+1 mod N_BANK, only when the selection came via round-robin.
- Simultaneous events:
  - A buffer may dequeue and refill in the same cycle.
  - A request to bank b may be accepted in the same cycle a bank b response is accepted.
- Forward progress: a write ack buffered in bank b becomes eligible once bank b's tracked read is oldest or retired. This prevents deadlock because the ROB always has one oldest entry.

Decomposition:
- N_BANK, BANK_ID_MSB/LSB, cpu_cache_if_req_t and cpu_cache_if_resp_t stay in pygmy_cfg/pygmy_typedef. No new typedefs.
- One sub-module: usb_noc_resp_arb, containing the eligibility, oldest-first/round-robin select, lock and rr_ptr.

Test Plan:
1. Reads A (paddr bank 2) then B (bank 0); bank 0 responds first with entry_vld=4'b0101, is_oldest=4'b0100 -> B held; A returned first; after is_oldest=4'b0001, B returned.
2. Write acks in banks 1 and 3 together, entry_vld=0, rr_ptr=0 -> bank 1 out first, then bank 3; rr_ptr ends at 0.
3. Response presented from bank 3 (no tracked read), ROB ready=0; next cycle entry_vld[3]=1 and is_oldest[3]=0 -> valid stays 1, same payload, until ready.
4. Four requests to bank 1 with no responses -> 5th ready=0; one bank 1 response accepted -> ready returns to 1 the next cycle.
5. Bank ready held 0 for 3 cycles -> noc_bank_req payload stable; ROB ready=0 while req_q full.
6. Assert rstn low mid-transfer with buffers full -> all valids 0 immediately (async); counters 0; after release, ready=1.
